// File: rtl/shift_register_universal.sv
// Universal shift register: parallel load, single step,
// and multi-cycle shift-by-N with busy/done handshake.
//
// Ports:
//   clk, areset_n    clock, async active-low reset
//   load, data       parallel load (highest priority)
//   start, amount    multi-cycle shift of amount positions
//   step             immediate one-position shift
//   mode             00 lsr, 01 lsl, 10 asr, 11 ror
//   ser_in           fill bit for logical shifts
//   q, ser_out       contents, last bit shifted out
//   busy, done       command in progress / completion pulse
module shift_register_universal #(
  parameter int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  input  logic             step,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam logic [AMT_W-1:0] AMT_MAX =
    AMT_W'(WIDTH);

  state_t           state;
  logic [1:0]       mode_r;
  logic [AMT_W-1:0] cnt;
  logic [AMT_W-1:0] amt_sat;

  assign amt_sat = (amount > AMT_MAX) ? AMT_MAX
                                      : amount;
  assign busy = (state == SHIFT);

  // Returns {bit shifted out, new contents}.
  function automatic logic [WIDTH:0] shift_one(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] v,
    input logic             si
  );
    logic [WIDTH:0] r;
    r = {1'b0, v};
    unique case (m)
      2'b00: r = {v[0], si, v[WIDTH-1:1]};
      2'b01: r = {v[WIDTH-1], v[WIDTH-2:0], si};
      2'b10: r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      2'b11: r = {v[0], v[0], v[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state   <= IDLE;
      mode_r  <= 2'b00;
      cnt     <= '0;
      q       <= '0;
      ser_out <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        // Also aborts a running command, no done.
        q     <= data;
        state <= IDLE;
      end else if (state == SHIFT) begin
        {ser_out, q} <= shift_one(mode_r, q, ser_in);
        cnt <= cnt - AMT_W'(1);
        if (cnt == AMT_W'(1)) begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end else if (start) begin
        if (amt_sat == '0) begin
          done <= 1'b1;
        end else begin
          mode_r <= mode;
          cnt    <= amt_sat;
          state  <= SHIFT;
        end
      end else if (step) begin
        {ser_out, q} <= shift_one(mode, q, ser_in);
      end
    end
  end

endmodule
